// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line blocks: FSM states, CRC7 constants,
// response frame layout and the field decode helper.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_DONE
    } rx_state_e;

    localparam int unsigned CRC_W     = 7;
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    localparam int unsigned FRAME_LEN    = 48;
    localparam int unsigned START_BIT    = 47;
    localparam int unsigned TRANS_BIT    = 46;
    localparam int unsigned INDEX_MSB    = 45;
    localparam int unsigned INDEX_LSB    = 40;
    localparam int unsigned ARG_MSB      = 39;
    localparam int unsigned ARG_LSB      = 8;
    localparam int unsigned CRC_MSB      = 7;
    localparam int unsigned CRC_LSB      = 1;
    localparam int unsigned END_BIT      = 0;
    localparam int unsigned CRC_LAST_BIT = ARG_LSB;

    localparam int unsigned INDEX_W = INDEX_MSB - INDEX_LSB + 1;
    localparam int unsigned ARG_W   = ARG_MSB - ARG_LSB + 1;
    localparam int unsigned POS_W   = 6;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [ARG_W-1:0]   arg;
        logic               crc_err;
        logic               trans_err;
        logic               end_err;
    } resp_t;

    // The start bit is always 0 once accepted, so only bits 46..0 are kept.
    function automatic resp_t decode_frame(input logic [FRAME_LEN-2:0] sr,
                                           input logic [CRC_W-1:0]     crc);
        resp_t r;
        r.index     = sr[INDEX_MSB:INDEX_LSB];
        r.arg       = sr[ARG_MSB:ARG_LSB];
        r.crc_err   = (sr[CRC_MSB:CRC_LSB] != crc);
        r.trans_err = sr[TRANS_BIT];
        r.end_err   = ~sr[END_BIT];
        return r;
    endfunction

endpackage

// File: rtl/sd_cmd_resp_rx_if.sv
// CMD response receiver bus: arm/serial input towards the receiver,
// decoded response fields and status back to the host logic.
interface sd_cmd_resp_rx_if import sd_pkg::*; ();

    logic               rx_enable;
    logic               cmd_in;
    logic               busy;
    logic               resp_valid;
    logic [INDEX_W-1:0] resp_index;
    logic [ARG_W-1:0]   resp_arg;
    logic               crc_err;
    logic               trans_err;
    logic               end_err;
    logic               timeout;

    modport master (
        output rx_enable, cmd_in,
        input  busy, resp_valid, resp_index, resp_arg,
               crc_err, trans_err, end_err, timeout
    );

    modport slave (
        input  rx_enable, cmd_in,
        output busy, resp_valid, resp_index, resp_arg,
               crc_err, trans_err, end_err, timeout
    );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first input, zero init; clear wins over shift.
module sd_crc7 import sd_pkg::*; (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[CRC_W-1];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (shift_en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (feedback ? CRC7_POLY : CRC_W'(0));
        end
    end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: hunts for the start bit within NCR_MAX samples,
// deserialises the 48-bit response and reports fields plus CRC/framing errors.
module sd_cmd_resp_rx import sd_pkg::*; #(
    parameter int unsigned NCR_MAX = 64
) (
    input  logic               clk,
    input  logic               reset,
    sd_cmd_resp_rx_if.slave    bus
);

    localparam int unsigned WAIT_W = $clog2(NCR_MAX + 1);

    rx_state_e            state, state_next;
    logic [WAIT_W-1:0]    wait_cnt, wait_cnt_next;
    logic [POS_W-1:0]     bit_pos, bit_pos_next;
    logic [FRAME_LEN-2:0] frame_sr;
    logic [CRC_W-1:0]     crc_val;

    logic  shift_en;
    logic  crc_clear;
    logic  crc_shift;
    logic  load_resp;
    logic  timeout_next;
    logic  busy_next;

    resp_t resp_q;
    resp_t resp_next;
    logic  resp_valid_q;
    logic  timeout_q;
    logic  busy_q;

    sd_crc7 u_crc7 (
        .clk      (clk),
        .reset    (reset),
        .clear    (crc_clear),
        .shift_en (crc_shift),
        .bit_in   (bus.cmd_in),
        .crc      (crc_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            bit_pos  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            bit_pos  <= bit_pos_next;
        end
    end

    // Next state and datapath controls; a window that has already seen
    // NCR_MAX idle ones times out regardless of the current sample.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        bit_pos_next  = bit_pos;
        shift_en      = 1'b0;
        crc_clear     = 1'b0;
        crc_shift     = 1'b0;
        load_resp     = 1'b0;
        timeout_next  = 1'b0;
        busy_next     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.rx_enable) begin
                    state_next    = ST_WAIT_START;
                    wait_cnt_next = '0;
                    crc_clear     = 1'b1;
                    busy_next     = 1'b1;
                end
            end
            ST_WAIT_START: begin
                busy_next = 1'b1;
                if (wait_cnt == WAIT_W'(NCR_MAX)) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                    busy_next    = 1'b0;
                end else if (!bus.cmd_in) begin
                    state_next   = ST_RECEIVE;
                    crc_shift    = 1'b1;
                    bit_pos_next = POS_W'(START_BIT - 1);
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            ST_RECEIVE: begin
                busy_next = 1'b1;
                shift_en  = 1'b1;
                crc_shift = (bit_pos >= POS_W'(CRC_LAST_BIT));
                if (bit_pos == '0) begin
                    state_next = ST_DONE;
                end else begin
                    bit_pos_next = bit_pos - POS_W'(1);
                end
            end
            ST_DONE: begin
                busy_next  = 1'b1;
                load_resp  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_sr <= '0;
        end else if (shift_en) begin
            frame_sr <= {frame_sr[FRAME_LEN-3:0], bus.cmd_in};
        end
    end

    assign resp_next = decode_frame(frame_sr, crc_val);

    // Fields hold until the next frame; a timeout clears only the error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            resp_valid_q <= load_resp;
            timeout_q    <= timeout_next;
            busy_q       <= busy_next;
            if (load_resp) begin
                resp_q <= resp_next;
            end else if (timeout_next) begin
                resp_q.crc_err   <= 1'b0;
                resp_q.trans_err <= 1'b0;
                resp_q.end_err   <= 1'b0;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.resp_index = resp_q.index;
    assign bus.resp_arg   = resp_q.arg;
    assign bus.crc_err    = resp_q.crc_err;
    assign bus.trans_err  = resp_q.trans_err;
    assign bus.end_err    = resp_q.end_err;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Directed bench for sd_cmd_resp_rx: valid/erroneous responses, timeout window
// boundary and mid-frame reset, all against hand-computed expectations.
module tb_sd_cmd_resp_rx;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    sd_cmd_resp_rx_if bus ();

    sd_cmd_resp_rx #(.NCR_MAX(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arms the receiver, sends idle ones then the frame MSB first, and waits
    // (bounded) for resp_valid; lat counts clocks from the start-bit edge.
    task automatic send_frame(input logic [47:0] frame, input int idle_ones,
                              output int lat, output bit saw_to);
        saw_to = 1'b0;
        bus.rx_enable = 1'b1;
        tick();
        bus.rx_enable = 1'b0;
        for (int i = 0; i < idle_ones; i++) begin
            bus.cmd_in = 1'b1;
            tick();
            if (bus.timeout) saw_to = 1'b1;
        end
        for (int i = 47; i >= 0; i--) begin
            bus.cmd_in = frame[i];
            tick();
            if (bus.timeout) saw_to = 1'b1;
        end
        bus.cmd_in = 1'b1;
        lat = 47;
        while (!bus.resp_valid && lat < 120) begin
            tick();
            lat++;
        end
    endtask

    task automatic expect_resp(input string pfx, input logic [47:0] frame, input int idle_ones,
                               input logic [5:0] idx, input logic [31:0] arg,
                               input logic ce, input logic te, input logic ee);
        int lat;
        bit saw_to;
        send_frame(frame, idle_ones, lat, saw_to);
        check({pfx, "_latency"}, 64'(lat), 64'(48));
        check({pfx, "_no_timeout"}, 64'(saw_to), 64'(0));
        check({pfx, "_index"}, 64'(bus.resp_index), 64'(idx));
        check({pfx, "_arg"}, 64'(bus.resp_arg), 64'(arg));
        check({pfx, "_crc_err"}, 64'(bus.crc_err), 64'(ce));
        check({pfx, "_trans_err"}, 64'(bus.trans_err), 64'(te));
        check({pfx, "_end_err"}, 64'(bus.end_err), 64'(ee));
        check({pfx, "_busy_in_valid"}, 64'(bus.busy), 64'(1));
        tick();
        check({pfx, "_valid_pulse"}, 64'(bus.resp_valid), 64'(0));
        check({pfx, "_busy_after"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_busy"}, 64'(bus.busy), 64'(0));
        check({pfx, "_valid"}, 64'(bus.resp_valid), 64'(0));
        check({pfx, "_timeout"}, 64'(bus.timeout), 64'(0));
        check({pfx, "_flags"}, 64'({bus.crc_err, bus.trans_err, bus.end_err}), 64'(0));
        check({pfx, "_index"}, 64'(bus.resp_index), 64'(0));
        check({pfx, "_arg"}, 64'(bus.resp_arg), 64'(0));
    endtask

    initial begin
        int  n;
        bit  saw_valid;
        logic [47:0] fr;

        reset = 1'b1;
        bus.rx_enable = 1'b0;
        bus.cmd_in = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_vals("por");

        expect_resp("r7_ok", 48'h08_000001AA_13, 5, 6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b0);
        expect_resp("host_dir", 48'h40_00000000_95, 3, 6'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        expect_resp("crc_flip", 48'h08_000011AA_13, 1, 6'd8, 32'h000011AA, 1'b1, 1'b0, 1'b0);
        expect_resp("end_bad", 48'h08_000001AA_12, 0, 6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b1);

        // Timeout: CMD held high for the whole window.
        bus.rx_enable = 1'b1;
        tick();
        bus.rx_enable = 1'b0;
        check("to_busy_armed", 64'(bus.busy), 64'(1));
        bus.cmd_in = 1'b1;
        n = 0;
        saw_valid = 1'b0;
        while (!bus.timeout && n < 100) begin
            tick();
            n++;
            if (bus.resp_valid) saw_valid = 1'b1;
        end
        check("to_latency", 64'(n), 64'(65));
        check("to_no_valid", 64'(saw_valid), 64'(0));
        check("to_busy_low", 64'(bus.busy), 64'(0));
        check("to_flags_cleared", 64'({bus.crc_err, bus.trans_err, bus.end_err}), 64'(0));
        check("to_index_held", 64'(bus.resp_index), 64'(8));
        check("to_arg_held", 64'(bus.resp_arg), 64'(32'h000001AA));
        tick();
        check("to_pulse", 64'(bus.timeout), 64'(0));

        // Start bit on the 64th sample of the window is still accepted.
        expect_resp("edge64", 48'h08_000001AA_13, 63, 6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame, just after bit 20 is sampled.
        fr = 48'h40_00000000_95;
        bus.rx_enable = 1'b1;
        tick();
        bus.rx_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.cmd_in = 1'b1;
            tick();
        end
        for (int i = 47; i >= 20; i--) begin
            bus.cmd_in = fr[i];
            tick();
        end
        reset = 1'b1;
        bus.cmd_in = 1'b0;
        tick();
        check_reset_vals("mid_rst");
        reset = 1'b0;
        bus.cmd_in = 1'b1;
        tick();
        check("mid_rst_idle", 64'(bus.busy), 64'(0));
        expect_resp("after_rst", 48'h08_000001AA_13, 2, 6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_resp_rx.md
# sd_cmd_resp_rx

Card-to-host receiver for the SD CMD line: samples the serial CMD input after the host command transmitter has finished a frame. It hunts for the start bit within a bounded response window, deserialises the 48-bit response and checks the CRC7 and framing bits. It reports the command index and 32-bit argument with error flags, or a timeout if no start bit arrives. It sits in the CMD path of the SD host, beside the command transmitter, and is synthesised with the rest of the CMD block against the shared CMOS cell library.

## Interface
- NCR_MAX, 64: number of idle CMD samples allowed before a start bit; exceeding it raises timeout.
- FRAME_LEN, 48: response frame length in bits; fixed for R1/R3/R6/R7.
- clk  in  1  SD clock; one CMD bit sampled per rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, sampled on clk.
- rx_enable  in  1  single-cycle pulse that arms the receiver; ignored unless IDLE.
- cmd_in  in  1  serial CMD line, already synchronised, MSB first.
- busy  out  1  high in WAIT_START, RECEIVE and DONE.
- resp_valid  out  1  one-cycle pulse: frame received, fields and flags valid.
- resp_index  out  6  frame bits [45:40].
- resp_arg  out  32  frame bits [39:8].
- crc_err  out  1  received CRC7 (bits [7:1]) differs from CRC7 computed over bits [47:8].
- trans_err  out  1  transmission bit [46] was not 0.
- end_err  out  1  end bit [0] was not 1.
- timeout  out  1  one-cycle pulse: no start bit within NCR_MAX samples.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE: rx_enable=1 -> WAIT_START, clear the window counter and CRC.
- WAIT_START: each cycle samples cmd_in.
  - cmd_in=0 -> RECEIVE; the start bit counts as frame bit 47 and feeds the CRC.
  - cmd_in=1 -> counter+1; when NCR_MAX consecutive 1s have been sampled -> IDLE with the timeout pulse.
- RECEIVE: shifts cmd_in into a 48-bit register, MSB first.
  - Bits 47..8 (40 bits) are fed to the serial CRC7 (polynomial x^7+x^3+1, init 0).
  - Bits 7..0 are stored only.
  - A 6-bit counter tracks the bit position; after bit 0 is sampled -> DONE.
- DONE: registers the fields and the three error flags, pulses resp_valid for one cycle, then -> IDLE.
- Errors are qualifiers only: resp_valid fires even when flags are set.
- Flags and fields hold until the next resp_valid or reset. timeout clears the error flags.
- rx_enable in any non-IDLE state is ignored; no abort input.
- Reset at any point forces IDLE within one cycle and discards any partial frame.
- Output reset values: busy=0, resp_valid=0, timeout=0, all flags 0, resp_index=0, resp_arg=0.

## Timing
- rx_enable sampled at edge n; the first WAIT_START sample is at edge n+1.
- Start bit sampled at edge t; bits 46..0 sampled at edges t+1..t+47.
- resp_valid high in the cycle following edge t+48; busy low from edge t+49.
- Latency from start bit to resp_valid: 48 clocks.
- Timeout: start bit accepted at the NCR_MAX-th sample at the latest (edge n+NCR_MAX). Otherwise timeout is high in the cycle following edge n+NCR_MAX+1, and IDLE follows.
- Earliest re-arm: rx_enable in the first IDLE cycle after resp_valid or timeout.
- All outputs are registered; there is no combinational path from cmd_in.

## Structure
- Shared package sd_pkg holds:
  - the state enum;
  - CRC7_POLY = 7'h09;
  - FRAME_LEN and the field bit positions (START=47, TRANS=46, INDEX 45:40, ARG 39:8, CRC 7:1, END=0).
- Sub-module sd_crc7: serial CRC7 with clear and shift-enable. It is shared with the command transmitter; do not inline it.

## Test plan
- Valid R7: rx_enable, 5 idle 1s, then frame 48'h08_000001AA_13 -> resp_valid 48 clocks after the start bit; index=8, arg=32'h000001AA; all flags 0.
- Host-direction frame 48'h40_00000000_95 -> index=0, arg=0, crc_err=0, trans_err=1, end_err=0.
- 48'h08_000001AA_13 with bit 20 flipped -> crc_err=1, arg=32'h000011AA.
- Valid R7 with end bit 0 (48'h08_000001AA_12) -> end_err=1 and crc_err=0.
- cmd_in held 1 -> timeout pulses once at n+NCR_MAX+1, resp_valid never fires, busy drops. Start bit at exactly sample 64 -> accepted with no timeout.
- Reset asserted mid-frame at bit 20 -> all outputs at reset values next cycle. A later rx_enable plus a valid frame decodes correctly, with no residue from the aborted frame.
